// File: rtl/rv32i_decode_stage_if.sv
// Stream bundle between fetch, the decode stage and execute.
// The stage takes the slave view; the fetch/execute side (or a bench) takes master.
interface rv32i_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [39:0]     out_flags;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic            out_rd_we;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_flags, out_rd, out_rs1, out_rs2,
               out_rd_we, out_imm, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_flags, out_rd, out_rs1, out_rs2,
               out_rd_we, out_imm, out_illegal
    );
endinterface

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: combinational decode of the incoming word, buffered in a
// DEPTH-entry FIFO towards execute, plus a saturating illegal-word counter.
module rv32i_decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    rv32i_decode_stage_if.slave  bus,
    output logic [CNT_W-1:0]     illegal_cnt
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [39:0]     flags;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rd_we;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    logic [31:0]        ins;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic               legal;
    logic [5:0]         op;
    logic               use_rd, use_rs1, use_rs2;
    logic signed [31:0] imm32;
    entry_t             dec;

    assign ins = bus.in_instr;
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    always_comb begin
        legal   = 1'b0;
        op      = 6'd0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        imm32   = '0;
        if (ins[1:0] == 2'b11) begin
            case (ins[6:2])
                5'b01101, 5'b00101: begin
                    legal  = 1'b1;
                    op     = ins[5] ? 6'd0 : 6'd1;
                    use_rd = 1'b1;
                    imm32  = {ins[31:12], 12'b0};
                end
                5'b11011: begin
                    legal  = 1'b1;
                    op     = 6'd2;
                    use_rd = 1'b1;
                    imm32  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
                end
                5'b11001: begin
                    legal   = (f3 == 3'b000);
                    op      = 6'd3;
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                    imm32   = {{20{ins[31]}}, ins[31:20]};
                end
                5'b11000: begin
                    legal   = !(f3 inside {3'b010, 3'b011});
                    op      = f3[2] ? 6'd4 + {3'b0, f3} - 6'd2 : 6'd4 + {3'b0, f3};
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    imm32   = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                end
                5'b00000: begin
                    legal   = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                    // lb,lh,lw occupy 10..12; lbu,lhu follow at 13..14
                    op      = f3[2] ? 6'd9 + {3'b0, f3} : 6'd10 + {3'b0, f3};
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                    imm32   = {{20{ins[31]}}, ins[31:20]};
                end
                5'b01000: begin
                    legal   = (f3 < 3'd3);
                    op      = 6'd15 + {3'b0, f3};
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    imm32   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                end
                5'b00100: begin
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                    imm32   = {{20{ins[31]}}, ins[31:20]};
                    legal   = 1'b1;
                    case (f3)
                        3'b000: op = 6'd18;
                        3'b010: op = 6'd19;
                        3'b011: op = 6'd20;
                        3'b100: op = 6'd21;
                        3'b110: op = 6'd22;
                        3'b111: op = 6'd23;
                        3'b001: begin
                            legal = (f7 == 7'b0000000);
                            op    = 6'd24;
                            imm32 = {27'b0, ins[24:20]};
                        end
                        default: begin
                            legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                            op    = f7[5] ? 6'd26 : 6'd25;
                            imm32 = {27'b0, ins[24:20]};
                        end
                    endcase
                end
                5'b01100: begin
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    if (f7 == 7'b0000000) begin
                        legal = 1'b1;
                        case (f3)
                            3'b000:  op = 6'd27;
                            3'b001:  op = 6'd29;
                            3'b010:  op = 6'd30;
                            3'b011:  op = 6'd31;
                            3'b100:  op = 6'd32;
                            3'b101:  op = 6'd33;
                            3'b110:  op = 6'd35;
                            default: op = 6'd36;
                        endcase
                    end else if (f7 == 7'b0100000) begin
                        legal = (f3 == 3'b000) || (f3 == 3'b101);
                        op    = f3[2] ? 6'd34 : 6'd28;
                    end
                end
                5'b00011: begin
                    legal = (f3 == 3'b000);
                    op    = 6'd37;
                end
                5'b11100: begin
                    legal = (ins == 32'h0000_0073) || (ins == 32'h0010_0073);
                    op    = ins[20] ? 6'd39 : 6'd38;
                end
                default: ;
            endcase
        end
    end

    // Illegal words carry no decoded fields at all, only the flag and pc.
    always_comb begin
        dec         = '0;
        dec.pc      = bus.in_pc;
        dec.illegal = !legal;
        dec.flags   = legal ? (40'd1 << op) : 40'd0;
        dec.rd      = (legal && use_rd)  ? ins[11:7]  : 5'd0;
        dec.rs1     = (legal && use_rs1) ? ins[19:15] : 5'd0;
        dec.rs2     = (legal && use_rs2) ? ins[24:20] : 5'd0;
        dec.rd_we   = legal && use_rd;
        dec.imm     = legal ? XLEN'(imm32) : '0;
    end

    entry_t            mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop;
    entry_t            head;

    assign bus.in_ready  = !flush && (count_q < DEPTH_C);
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + (AW+1)'(1);
            else if (!push && pop) count_d = count_q - (AW+1)'(1);
        end
        if (push && !legal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec;
    end

    // Gating on out_valid makes every output read zero while reset is held.
    assign head            = bus.out_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.out_pc      = head.pc;
    assign bus.out_flags   = head.flags;
    assign bus.out_rd      = head.rd;
    assign bus.out_rs1     = head.rs1;
    assign bus.out_rs2     = head.rs2;
    assign bus.out_rd_we   = head.rd_we;
    assign bus.out_imm     = head.imm;
    assign bus.out_illegal = head.illegal;
    assign illegal_cnt     = cnt_q;
endmodule

// File: doc/rv32i_decode_stage.md
# rv32i_decode_stage

Registered, parametrised RV32I decode stage between instruction fetch and execute. It accepts instruction words over a valid/ready handshake and fully decodes each one into a one-hot operation vector, register indices, an XLEN sign-extended immediate and an illegal-instruction flag. Decoded entries are buffered in a DEPTH-entry FIFO so that execute back-pressure does not stall fetch immediately. A synchronous flush and a saturating illegal-instruction counter are also provided.

## Interface
- XLEN, 32: width of pc and imm; must be at least 32; the immediate is sign-extended to XLEN.
- DEPTH, 2: FIFO entries; power of two, at least 2.
- CNT_W, 16: width of the illegal-instruction counter.
- clk  in  1  Single clock; all state updates on the rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- flush  in  1  Synchronous; empties the FIFO.
- in_valid  in  1  Input word present.
- in_ready  out  1  Stage can accept a word.
- in_instr  in  32  Instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  Head entry valid.
- out_ready  in  1  Execute accepts the head entry.
- out_pc  out  XLEN  Head PC.
- out_flags  out  40  One-hot operation. Bit order from LSB: lui, auipc, jal, jalr, beq, bne, blt, bge, bltu, bgeu, lb, lh, lw, lbu, lhu, sb, sh, sw, addi, slti, sltiu, xori, ori, andi, slli, srli, srai, add, sub, sll, slt, sltu, xor, srl, sra, or, and, fence, ecall, ebreak.
- out_rd, out_rs1, out_rs2  out  5 each  Register indices.
- out_rd_we  out  1  Instruction writes rd.
- out_imm  out  XLEN  Sign-extended immediate.
- out_illegal  out  1  Head entry is illegal.
- illegal_cnt  out  CNT_W  Saturating count of illegal words accepted.

## Operation
- **Decode:** combinational on in_instr; the result is written into the FIFO on acceptance.
- **Immediate by format:**
  - I-type (jalr, loads, ALU-immediate): [31:20].
  - S-type: {[31:25],[11:7]}.
  - B-type: {[31],[7],[30:25],[11:8],0}.
  - U-type: {[31:12],12'b0}.
  - J-type: {[31],[19:12],[20],[30:21],0}.
  - R-type, fence, ecall, ebreak: 0.
  - For slli/srli/srai, imm = shamt [24:20], zero-extended.
- **Unused fields are zeroed:**
  - rs2 = 0 for everything except R-type, stores and branches.
  - rs1 = 0 for lui, auipc, jal, fence, ecall and ebreak.
  - rd = 0 and rd_we = 0 for stores, branches, fence, ecall and ebreak.
  - rd_we = 1 for all other legal instructions, including rd = x0.
- **Illegal encodings:** flags = 0, illegal = 1, rd/rs1/rs2/imm = 0, rd_we = 0.
  - [1:0] != 2'b11.
  - Unknown opcode.
  - jalr with funct3 != 0.
  - Branch with funct3 010 or 011.
  - Load with funct3 011, 110 or 111.
  - Store with funct3 >= 3.
  - Shift-immediate with [31:25] not 0000000 (or 0100000 for srai).
  - R-type with funct7 not 0000000, or 0100000 with funct3 other than 000/101.
  - fence with funct3 != 000.
  - Any SYSTEM word other than exactly 0x00000073 (ecall) or 0x00100073 (ebreak); CSR instructions are illegal.
- **FIFO:**
  - in_ready = !flush && (count < DEPTH). There is no same-cycle pass-through when full.
  - Push on in_valid && in_ready.
  - Pop on out_valid && out_ready && !flush.
  - Push and pop in the same cycle leaves count unchanged.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- **out_\* outputs** always show the head entry. They hold stable while out_valid && !out_ready.
- **Flush:** count := 0 and pointers := 0. The flush-cycle input is not accepted and any pop is ignored.
- **illegal_cnt:** increments on each accepted illegal word and saturates at 2^CNT_W-1. It is not cleared by flush.

## Timing
- **Reset (rst_n low, asynchronous):**
  - FIFO empty; out_valid = 0; in_ready = 1 once rst_n is high.
  - All out_\* data outputs = 0.
  - illegal_cnt = 0.
  - Reset asserted mid-transfer discards all entries.
- **Latency:**
  - A word accepted at edge N into an empty FIFO gives out_valid = 1 after edge N.
  - Throughput is 1 word/cycle when out_ready is held at 1.
- **Full:**
  - After DEPTH pushes without a pop, in_ready drops in the following cycle.
  - A pop at edge M raises in_ready after M.
- **Empty:** out_valid = 0. The out_\* data outputs are don't-care and need not be held.

## Test plan
- **Single decode:** reset, then push 0xFFF00093 (addi x1,x0,-1) with pc 0x100 and out_ready = 1.
  - Next cycle: out_valid = 1, flags bit 18 set, rd = 1, rs1 = 0, rs2 = 0, rd_we = 1, imm = 0xFFFFFFFF, out_pc = 0x100.
- **R-type and branch:** push 0x402081B3 (sub x3,x1,x2), then 0x00208463 (beq x1,x2,+8).
  - sub: bit 28 set, rd = 3, rs1 = 1, rs2 = 2, imm = 0.
  - beq: bit 4 set, rd = 0, rd_we = 0, rs1 = 1, rs2 = 2, imm = 8.
- **Back-pressure:** DEPTH = 2, out_ready = 0, push three words back-to-back.
  - The first two are accepted; in_ready = 0 on the third cycle.
  - Raising out_ready pops them in order with the head held stable while stalled, and the third word is then accepted.
- **Illegal:** push 0x00000000, 0x00001073 (csrrw) and 0x0000A023 (funct3 010 store, legal sw).
  - The first two give illegal = 1 with flags = 0; the third sets bit 17.
  - illegal_cnt = 2.
  - With CNT_W = 2, five illegal words saturate illegal_cnt at 3.
- **Flush:** fill the FIFO, then assert flush for one cycle with in_valid = 1 and out_ready = 1.
  - Next cycle: out_valid = 0, nothing was popped or pushed, illegal_cnt unchanged.
- **Async reset mid-stream:** drop rst_n between edges while the FIFO holds 2 entries.
  - out_valid and all outputs go to 0 immediately, before the next clock edge.
